// File: rtl/heartbeat_rx.sv
// Manchester receiver for the heartbeat link: recovers bit timing from an
// oversampled line and aligns bytes using the incrementing-counter payload.
//
// state     | meaning
// ----------+------------------------------------------------------------
// B_SEARCH  | no bit timing; any edge after a long gap is taken as mid-bit
// B_TRACK   | bit timing held; short-gap edges blanked, timeout drops lock
// Y_HUNT    | test every bit position for a consecutive byte pair
// Y_CONFIRM | candidate alignment found; next byte must equal exp
// Y_LOCKED  | aligned; every 8th bit emits a byte and re-checks the count
module heartbeat_rx #(
  parameter int HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       bit_locked,
  output logic       byte_locked,
  output logic [7:0] err_count
);

  localparam int LONG    = (3 * HALF) / 2;
  localparam int TIMEOUT = (5 * HALF) / 2;
  localparam logic [7:0] LONG_C = 8'(LONG);
  localparam logic [7:0] TMO_C  = 8'(TIMEOUT);

  typedef enum logic {
    B_SEARCH,
    B_TRACK
  } bit_state_t;

  typedef enum logic [1:0] {
    Y_HUNT,
    Y_CONFIRM,
    Y_LOCKED
  } byte_state_t;

  logic        s1_q, s2_q, s3_q;
  logic [7:0]  ivl_q, ivl_d, ivl_inc;
  bit_state_t  bst_q, bst_d;
  byte_state_t yst_q, yst_d;
  logic [15:0] sr_q, sr_d, sr_shift;
  logic [2:0]  bc_q, bc_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  hi_inc, lo_inc;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic        bit_locked_q, bit_locked_d;
  logic        byte_locked_q, byte_locked_d;
  logic [7:0]  err_q, err_d;
  logic        edge_det, long_gap, bit_stb, drop, byte_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= rx_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q ^ s3_q;
  assign long_gap = (ivl_q >= LONG_C);
  assign ivl_inc  = (ivl_q == 8'hFF) ? ivl_q : ivl_q + 8'd1;

  // The decoded bit is the level before the mid-bit transition, i.e. s3.
  assign sr_shift = {sr_q[14:0], s3_q};
  assign hi_inc   = sr_shift[15:8] + 8'd1;
  assign lo_inc   = sr_shift[7:0] + 8'd1;

  always_comb begin
    bst_d        = bst_q;
    ivl_d        = ivl_inc;
    bit_locked_d = bit_locked_q;
    bit_stb      = 1'b0;
    drop         = 1'b0;
    case (bst_q)
      B_SEARCH: begin
        if (edge_det) begin
          ivl_d = 8'd0;
          if (long_gap) begin
            bst_d        = B_TRACK;
            bit_locked_d = 1'b1;
            bit_stb      = 1'b1;
          end
        end
      end
      B_TRACK: begin
        if (edge_det && long_gap) begin
          ivl_d   = 8'd0;
          bit_stb = 1'b1;
        end else if (ivl_inc >= TMO_C) begin
          bst_d        = B_SEARCH;
          bit_locked_d = 1'b0;
          drop         = 1'b1;
        end
      end
      default: begin
        bst_d        = B_SEARCH;
        bit_locked_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    yst_d         = yst_q;
    sr_d          = sr_q;
    bc_d          = bc_q;
    exp_d         = exp_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    byte_locked_d = byte_locked_q;
    byte_err      = 1'b0;
    if (drop) begin
      yst_d         = Y_HUNT;
      sr_d          = 16'd0;
      bc_d          = 3'd0;
      byte_locked_d = 1'b0;
    end else if (bit_stb) begin
      sr_d = sr_shift;
      bc_d = bc_q + 3'd1;
      case (yst_q)
        Y_HUNT: begin
          if (sr_shift[7:0] == hi_inc) begin
            yst_d = Y_CONFIRM;
            exp_d = lo_inc;
            bc_d  = 3'd0;
          end
        end
        Y_CONFIRM: begin
          if (bc_q == 3'd7) begin
            if (sr_shift[7:0] == exp_q) begin
              yst_d         = Y_LOCKED;
              byte_locked_d = 1'b1;
              byte_out_d    = sr_shift[7:0];
              byte_valid_d  = 1'b1;
              exp_d         = lo_inc;
            end else begin
              yst_d = Y_HUNT;
            end
          end
        end
        Y_LOCKED: begin
          if (bc_q == 3'd7) begin
            byte_out_d   = sr_shift[7:0];
            byte_valid_d = 1'b1;
            if (sr_shift[7:0] != exp_q) begin
              yst_d         = Y_HUNT;
              byte_locked_d = 1'b0;
              byte_err      = 1'b1;
            end else begin
              exp_d = lo_inc;
            end
          end
        end
        default: yst_d = Y_HUNT;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if ((drop || byte_err) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ivl_q         <= 8'd0;
      bst_q         <= B_SEARCH;
      yst_q         <= Y_HUNT;
      sr_q          <= 16'd0;
      bc_q          <= 3'd0;
      exp_q         <= 8'd0;
      byte_out_q    <= 8'd0;
      byte_valid_q  <= 1'b0;
      bit_locked_q  <= 1'b0;
      byte_locked_q <= 1'b0;
      err_q         <= 8'd0;
    end else begin
      ivl_q         <= ivl_d;
      bst_q         <= bst_d;
      yst_q         <= yst_d;
      sr_q          <= sr_d;
      bc_q          <= bc_d;
      exp_q         <= exp_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      bit_locked_q  <= bit_locked_d;
      byte_locked_q <= byte_locked_d;
      err_q         <= err_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign bit_locked  = bit_locked_q;
  assign byte_locked = byte_locked_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_heartbeat_rx.sv
// Bench for heartbeat_rx: a Manchester transmitter model records when each
// byte's last mid-bit transition happens; the receiver must echo it 3 edges later.
module tb_heartbeat_rx;

  localparam int HALF    = 4;
  localparam int TIMEOUT = (5 * HALF) / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       bit_locked;
  logic       byte_locked;
  logic [7:0] err_count;

  heartbeat_rx #(.HALF(HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .bit_locked (bit_locked),
    .byte_locked(byte_locked),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_at[int];
  logic [7:0] rxq[$];
  int bl_rise_cyc = -1;
  int bl_fall_cyc = -1;
  int byl_fall_cyc = -1;
  int byl_falls = 0;
  int first_mid = -1;
  int last_mid = 0;
  logic prev_bv = 1'b0;
  logic prev_bl = 1'b0;
  logic prev_byl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i >= 0 && i < rxq.size()) return {24'd0, rxq[i]};
    return 32'hDEAD;
  endfunction

  // Every strobe must land exactly 3 edges after some byte's last mid-bit transition.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        chk("byte_timing", exp_at.exists(cyc), 1);
        if (exp_at.exists(cyc)) chk("byte_value", {24'd0, byte_out}, {24'd0, exp_at[cyc]});
        chk("valid_back_to_back", {31'd0, prev_bv}, 0);
        rxq.push_back(byte_out);
      end
      if (bit_locked && !prev_bl) bl_rise_cyc = cyc;
      if (!bit_locked && prev_bl) bl_fall_cyc = cyc;
      if (!byte_locked && prev_byl) begin
        byl_fall_cyc = cyc;
        byl_falls++;
      end
    end
    prev_bv  = byte_valid;
    prev_bl  = bit_locked;
    prev_byl = byte_locked;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit = -1);
    for (int i = 7; i >= 0; i--) begin
      rx_in = b[i];
      tick(HALF);
      rx_in = ~b[i];
      if (first_mid < 0) first_mid = cyc;
      last_mid = cyc;
      if (i == 0) exp_at[cyc + 3] = b;
      if (i == glitch_bit) begin
        tick(2);
        rx_in = b[i];
        tick(1);
        rx_in = ~b[i];
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_out"}, {24'd0, byte_out}, 0);
    chk({tag, "_byte_valid"}, {31'd0, byte_valid}, 0);
    chk({tag, "_bit_locked"}, {31'd0, bit_locked}, 0);
    chk({tag, "_byte_locked"}, {31'd0, byte_locked}, 0);
    chk({tag, "_err_count"}, {24'd0, err_count}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int gb;
    int found;
    logic [7:0] v;
    logic [7:0] s;

    rst   = 1'b1;
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx_in = ~rx_in;
      tick(1);
    end
    chk_all_zero("reset_held");

    rx_in = 1'b0;
    rst   = 1'b0;
    tick(100);
    chk_all_zero("idle_after_reset");

    // Lock from 0x00 with the line idling at the first bit's level.
    rxq.delete();
    first_mid   = -1;
    bl_rise_cyc = -1;
    for (int b = 0; b < 24; b++) send_byte(8'(b));
    chk("lock_bit_rise_cycle", bl_rise_cyc, first_mid + 3);
    chk("lock_first_le_04", {31'd0, (q_at(0) <= 32'h04)}, 1);
    chk("lock_nbytes_ge_21", {31'd0, (rxq.size() >= 21)}, 1);
    chk("lock_last_byte", q_at(rxq.size() - 1), 32'h17);
    chk("lock_err", {24'd0, err_count}, 0);
    chk("lock_byte_locked", {31'd0, byte_locked}, 1);

    // Corrupt 0x40 into 0x48.
    for (int b = 8'h18; b < 8'h40; b++) send_byte(8'(b));
    rxq.delete();
    send_byte(8'h48);
    chk("corrupt_emitted", q_at(0), 32'h48);
    chk("corrupt_unlocked", {31'd0, byte_locked}, 0);
    chk("corrupt_err", {24'd0, err_count}, 1);
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    chk("corrupt_relock", {31'd0, byte_locked}, 1);
    chk("corrupt_nbytes", rxq.size(), 2);
    chk("corrupt_first_after", q_at(1), 32'h43);
    send_byte(8'h44);
    send_byte(8'h45);

    // Single-cycle glitch 2 cycles after a random mid-bit edge.
    snap = byl_falls;
    gb   = int'($urandom_range(0, 7));
    send_byte(8'h46, gb);
    for (int b = 8'h47; b < 8'h50; b++) send_byte(8'(b));
    chk("glitch_err", {24'd0, err_count}, 1);
    chk("glitch_locked", {31'd0, byte_locked}, 1);
    chk("glitch_no_unlock", byl_falls, snap);
    chk("glitch_last", q_at(rxq.size() - 1), 32'h4F);

    // Dropout: hold the line high for 40 cycles.
    for (int b = 8'h50; b < 8'h80; b++) send_byte(8'(b));
    chk("drop_pre_locked", {31'd0, byte_locked}, 1);
    rx_in = 1'b1;
    tick(40);
    chk("drop_bit_fall_cycle", bl_fall_cyc, last_mid + 3 + TIMEOUT);
    chk("drop_byte_fall_cycle", byl_fall_cyc, last_mid + 3 + TIMEOUT);
    chk("drop_bit_locked", {31'd0, bit_locked}, 0);
    chk("drop_err", {24'd0, err_count}, 2);
    rxq.delete();
    for (int b = 8'h80; b < 8'h86; b++) send_byte(8'(b));
    chk("drop_relock_bit", {31'd0, bit_locked}, 1);
    chk("drop_relock_byte", {31'd0, byte_locked}, 1);
    chk("drop_relock_nbytes", rxq.size(), 4);
    chk("drop_relock_first", q_at(0), 32'h82);
    chk("drop_relock_err", {24'd0, err_count}, 2);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    rst = 1'b1;
    #1;
    chk_all_zero("midstream_reset");
    rx_in = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);

    // Wrap through 0xFF -> 0x00.
    rxq.delete();
    snap = 0;
    v = 8'hF8;
    repeat (12) begin
      send_byte(v);
      if (v == 8'hFC) begin
        snap = byl_falls;
        chk("wrap_locked_before", {31'd0, byte_locked}, 1);
      end
      v = v + 8'd1;
    end
    found = 0;
    for (int i = 0; i + 1 < rxq.size(); i++)
      if (rxq[i] == 8'hFF && rxq[i + 1] == 8'h00) found = 1;
    chk("wrap_ff_to_00", found, 1);
    chk("wrap_no_unlock", byl_falls, snap);
    chk("wrap_last", q_at(rxq.size() - 1), 32'h03);
    chk("wrap_err", {24'd0, err_count}, 0);

    // Random start value from a fresh reset.
    rst = 1'b1;
    tick(2);
    s = 8'($urandom_range(0, 255));
    rx_in = s[7];
    rst = 1'b0;
    tick(30);
    rxq.delete();
    first_mid   = -1;
    bl_rise_cyc = -1;
    v = s;
    repeat (14) begin
      send_byte(v);
      v = v + 8'd1;
    end
    chk("rand_bit_rise_cycle", bl_rise_cyc, first_mid + 3);
    chk("rand_nbytes_ge_6", {31'd0, (rxq.size() >= 6)}, 1);
    chk("rand_last", q_at(rxq.size() - 1), {24'd0, 8'(s + 8'd13)});
    chk("rand_locked", {31'd0, byte_locked}, 1);
    chk("rand_err", {24'd0, err_count}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
